// File: rtl/control_seq.sv
// Instruction sequencer: a FETCH/EXEC/MEM controller that fetches halfword instructions,
// steers register-write and ALU operand muxes, resolves branches and counts retired instructions.
module control_seq #(
  parameter int unsigned XLEN       = 16,
  parameter int unsigned IMM_W      = 8,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned REL_BRANCH = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       flags,
  input  logic [7:0]       ctrl_flags,
  input  logic             imm3,
  input  logic [XLEN-1:0]  reg_o0,
  input  logic [XLEN-1:0]  reg_o2,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_half,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  reg_in,
  output logic             reg_we,
  output logic [XLEN-1:0]  alu_b,
  output logic [XLEN-2:0]  pc,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned      PC_W    = XLEN - 1;
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;

  logic            cond_s, adi_s, ipc_s, wpc_s, spc_s, mem_we_op_s, mem_re_op_s, ldi_s;
  logic            mem_op_s, cond_true_s, take_s;
  logic [PC_W-1:0] target_s;

  assign cond_s      = ctrl_flags[7];
  assign adi_s       = ctrl_flags[6];
  assign ipc_s       = ctrl_flags[5];
  assign wpc_s       = ctrl_flags[4];
  assign spc_s       = ctrl_flags[3];
  assign mem_we_op_s = ctrl_flags[2];
  assign mem_re_op_s = ctrl_flags[1];
  assign ldi_s       = ctrl_flags[0];
  assign mem_op_s    = mem_we_op_s | mem_re_op_s;

  // Branch condition and target; pc_q already holds the post-fetch increment here.
  always_comb begin
    cond_true_s = 1'b0;
    target_s    = pc_q;
    case (inst_q[11:10])
      2'b00:   cond_true_s = 1'b1;
      2'b01:   cond_true_s = flags[0];
      2'b10:   cond_true_s = flags[1];
      2'b11:   cond_true_s = ~flags[0] | ~flags[1];
      default: cond_true_s = 1'b0;
    endcase
    if (wpc_s) begin
      target_s = alu_out[XLEN-1:1];
    end else if (REL_BRANCH != 0) begin
      target_s = pc_q + PC_W'($signed(inst_q[IMM_W-1:1]));
    end else begin
      target_s = PC_W'(inst_q[IMM_W-1:1]);
    end
  end

  assign take_s = (wpc_s | ipc_s) & (~cond_s | cond_true_s);

  // Next-state logic and memory/register strobes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    cnt_d    = cnt_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_half = 1'b0;
    mem_addr = {pc_q, 1'b0};
    reg_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = run_q;
        mem_half = 1'b1;
        if (run_q && mem_ack) begin
          inst_d  = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (mem_op_s) begin
          state_d = S_MEM;
        end else begin
          reg_we  = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_FETCH;
          if (take_s) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_out;
        mem_we   = mem_we_op_s;
        mem_half = inst_q[3];
        if (mem_ack) begin
          reg_we  = ~mem_we_op_s;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Register write data and ALU operand B selection.
  always_comb begin
    reg_in = alu_out;
    alu_b  = reg_o2;
    if (spc_s) begin
      reg_in = {pc_q, 1'b0};
    end else if (ldi_s) begin
      reg_in = XLEN'($signed(inst_q[IMM_W-1:0]));
    end else if (state_q == S_MEM) begin
      reg_in = mem_rdata;
    end else begin
      reg_in = alu_out;
    end
    if (adi_s) begin
      alu_b = XLEN'($signed(inst_q[3:0]));
    end else if (imm3) begin
      alu_b = XLEN'(inst_q[2:0]);
    end else begin
      alu_b = reg_o2;
    end
  end

  // State registers; run_q keeps mem_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= PC_W'(RESET_PC);
      inst_q  <= {XLEN{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  assign mem_wdata  = reg_o0;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: two instances (absolute and PC-relative branches) share stimulus;
// register writes are predicted into a scoreboard queue and popped when reg_we fires.
module tb_control_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  flags;
  logic [7:0]  ctrl_flags;
  logic        imm3;
  logic [15:0] reg_o0, reg_o2, alu_out, mem_rdata;
  logic        mem_ack;

  logic        mem_req, mem_we, mem_half, reg_we;
  logic [15:0] mem_addr, mem_wdata, inst, reg_in, alu_b;
  logic [14:0] pc;
  logic [3:0]  retire_cnt;

  logic        mem_req_b, mem_we_b, mem_half_b, reg_we_b;
  logic [15:0] mem_addr_b, mem_wdata_b, inst_b, reg_in_b, alu_b_b;
  logic [14:0] pc_b;
  logic [3:0]  retire_cnt_b;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  logic [14:0] pa, pb;
  logic [3:0]  cnt;
  logic [15:0] inst_m;

  always #5 clk = ~clk;

  control_seq #(.XLEN(16), .IMM_W(8), .RESET_PC(16), .REL_BRANCH(0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flags(flags), .ctrl_flags(ctrl_flags), .imm3(imm3),
    .reg_o0(reg_o0), .reg_o2(reg_o2), .alu_out(alu_out), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_half(mem_half), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .inst(inst), .reg_in(reg_in), .reg_we(reg_we), .alu_b(alu_b),
    .pc(pc), .retire_cnt(retire_cnt)
  );

  control_seq #(.XLEN(16), .IMM_W(8), .RESET_PC(16), .REL_BRANCH(1), .CNT_W(4)) dut_rel (
    .clk(clk), .rst_n(rst_n), .flags(flags), .ctrl_flags(ctrl_flags), .imm3(imm3),
    .reg_o0(reg_o0), .reg_o2(reg_o2), .alu_out(alu_out), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_half(mem_half_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .inst(inst_b), .reg_in(reg_in_b), .reg_we(reg_we_b), .alu_b(alu_b_b),
    .pc(pc_b), .retire_cnt(retire_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch with wait_n stall cycles before mem_ack; leaves the bench inside the acking cycle.
  task automatic fetch(input logic [15:0] word, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      ctrl_flags = 8'h00; mem_ack = 1'b0; mem_rdata = 16'hDEAD;
      #1;
      chk("fw_req", mem_req, 32'd1);
      chk("fw_addr", mem_addr, {pa, 1'b0});
      chk("fw_inst", inst, inst_m);
    end
    @(negedge clk);
    ctrl_flags = 8'h00; mem_ack = 1'b1; mem_rdata = word;
    #1;
    chk("f_req", mem_req, 32'd1);
    chk("f_addr", mem_addr, {pa, 1'b0});
    chk("f_half", mem_half, 32'd1);
    chk("f_we", mem_we, 32'd0);
    chk("f_reg_we", reg_we, 32'd0);
    chk("f_pc_rel", pc_b, pb);
    chk("f_cnt", retire_cnt, cnt);
    inst_m = word;
    pa = pa + 15'd1;
    pb = pb + 15'd1;
  endtask

  // Non-memory EXEC cycle; npa/npb are the predicted pcs afterwards for each instance.
  task automatic exec_alu(input logic [7:0] cf, input logic [1:0] fl, input logic [15:0] aout,
                          input logic [15:0] exp_in, input logic [14:0] npa, input logic [14:0] npb);
    logic [15:0] e;
    @(negedge clk);
    ctrl_flags = cf; flags = fl; alu_out = aout; mem_ack = 1'b1; mem_rdata = 16'h7777;
    sb.push_back(exp_in);
    #1;
    chk("e_req", mem_req, 32'd0);
    chk("e_inst", inst, inst_m);
    chk("e_pc", pc, pa);
    chk("e_pc_rel", pc_b, pb);
    chk("e_reg_we", reg_we, 32'd1);
    e = sb.pop_front();
    if (reg_we === 1'b1) chk("e_reg_in", reg_in, e);
    pa = npa;
    pb = npb;
    cnt = cnt + 4'd1;
  endtask

  // Load (cf[2]=0) or store (cf[2]=1) through EXEC and MEM with wait_n stall cycles.
  task automatic exec_mem(input logic [7:0] cf, input logic [15:0] addr, input logic [15:0] rdata,
                          input int wait_n);
    logic        load;
    logic [15:0] e;
    load = ~cf[2];
    @(negedge clk);
    ctrl_flags = cf; alu_out = addr; mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1;
    chk("x_req", mem_req, 32'd0);
    chk("x_reg_we", reg_we, 32'd0);
    chk("x_pc", pc, pa);
    if (load) sb.push_back(rdata);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'hDEAD;
      #1;
      chk("mw_req", mem_req, 32'd1);
      chk("mw_addr", mem_addr, addr);
      chk("mw_we", mem_we, {31'd0, ~load});
      chk("mw_half", mem_half, {31'd0, inst_m[3]});
      chk("mw_reg_we", reg_we, 32'd0);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = rdata;
    #1;
    chk("m_req", mem_req, 32'd1);
    chk("m_addr", mem_addr, addr);
    chk("m_we", mem_we, {31'd0, ~load});
    chk("m_half", mem_half, {31'd0, inst_m[3]});
    chk("m_wdata", mem_wdata, reg_o0);
    chk("m_reg_we", reg_we, {31'd0, load});
    if (load) begin
      e = sb.pop_front();
      if (reg_we === 1'b1) chk("m_reg_in", reg_in, e);
    end
    cnt = cnt + 4'd1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; flags = 2'b00; ctrl_flags = 8'h00; imm3 = 1'b0;
    reg_o0 = 16'h0000; reg_o2 = 16'h0000; alu_out = 16'h0000; mem_rdata = 16'h0000; mem_ack = 1'b1;
    pa = 15'h0010; pb = 15'h0010; cnt = 4'd0; inst_m = 16'h0000;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mem_req, 32'd0);
    chk("rst_reg_we", reg_we, 32'd0);
    chk("rst_pc", pc, 32'h10);
    chk("rst_inst", inst, 32'h0);
    chk("rst_cnt", retire_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_low", mem_req, 32'd0);

    // first fetch after reset from RESET_PC
    fetch(16'h0000, 0);
    chk("req020_addr", mem_addr, 32'h0020);
    exec_alu(8'h00, 2'b00, 16'h1234, 16'h1234, pa, pb);

    // ALU operand B selection
    fetch(16'h000D, 0);
    exec_alu(8'h40, 2'b00, 16'h0001, 16'h0001, pa, pb);
    chk("alub_adi", alu_b, 32'hFFFD);
    imm3 = 1'b1;
    fetch(16'h000D, 0);
    exec_alu(8'h00, 2'b00, 16'h0002, 16'h0002, pa, pb);
    chk("alub_imm3", alu_b, 32'h0005);
    fetch(16'h000D, 0);
    exec_alu(8'h40, 2'b00, 16'h0003, 16'h0003, pa, pb);
    chk("alub_prio", alu_b, 32'hFFFD);
    imm3 = 1'b0; reg_o2 = 16'hA5A5;
    fetch(16'h000D, 0);
    exec_alu(8'h00, 2'b00, 16'h0004, 16'h0004, pa, pb);
    chk("alub_reg", alu_b, 32'hA5A5);

    // stalled fetch
    fetch(16'h0123, 3);
    exec_alu(8'h00, 2'b00, 16'h0456, 16'h0456, pa, pb);

    // halfword load, then byte store
    fetch(16'h0008, 0);
    exec_mem(8'h02, 16'h0100, 16'hBEEF, 1);
    reg_o0 = 16'h5A5A;
    fetch(16'h0000, 0);
    exec_mem(8'h04, 16'h0202, 16'h3333, 2);

    // reg_in sources: spc, ldi negative/positive, spc over ldi
    fetch(16'h0000, 0);
    exec_alu(8'h08, 2'b00, 16'h1111, {pa, 1'b0}, pa, pb);
    fetch(16'h0080, 0);
    exec_alu(8'h01, 2'b00, 16'h1111, 16'hFF80, pa, pb);
    fetch(16'h0075, 0);
    exec_alu(8'h01, 2'b00, 16'h1111, 16'h0075, pa, pb);
    fetch(16'h0080, 0);
    exec_alu(8'h09, 2'b00, 16'h1111, {pa, 1'b0}, pa, pb);

    // conditional ipc branches
    fetch(16'h0440, 0);
    exec_alu(8'hA0, 2'b00, 16'h0042, 16'h0042, pa, pb);
    fetch(16'h0440, 0);
    exec_alu(8'hA0, 2'b01, 16'h0042, 16'h0042, 15'h0020, pb + 15'h0020);
    fetch(16'h0000, 0);
    chk("req023_pc", pc, 32'h20);
    exec_alu(8'h00, 2'b00, 16'h0001, 16'h0001, pa, pb);
    fetch(16'h0C40, 0);
    exec_alu(8'hA0, 2'b11, 16'h0043, 16'h0043, pa, pb);
    fetch(16'h0840, 0);
    exec_alu(8'hA0, 2'b10, 16'h0044, 16'h0044, 15'h0020, pb + 15'h0020);

    // wpc has priority over ipc
    fetch(16'h0040, 0);
    exec_alu(8'h30, 2'b00, 16'h0008, 16'h0008, 15'h0004, 15'h0004);

    // unconditional ipc: absolute vs relative backwards
    fetch(16'h00FC, 0);
    exec_alu(8'h20, 2'b00, 16'h1111, 16'h1111, 15'h007E, 15'h0003);
    fetch(16'h0000, 0);
    chk("req024_pc_rel", pc_b, 32'h0003);
    chk("req024_pc_abs", pc, 32'h007E);
    exec_alu(8'h00, 2'b00, 16'h0001, 16'h0001, pa, pb);

    // retire counter wrap
    while (cnt != 4'hF) begin
      fetch(16'h0000, 0);
      exec_alu(8'h00, 2'b00, 16'h0001, 16'h0001, pa, pb);
    end
    fetch(16'h0000, 0);
    chk("req025_full", retire_cnt, 32'hF);
    exec_alu(8'h00, 2'b00, 16'h0001, 16'h0001, pa, pb);
    fetch(16'h0000, 0);
    chk("req025_wrap", retire_cnt, 32'h0);

    // reset in the middle of a load
    @(negedge clk);
    ctrl_flags = 8'h02; alu_out = 16'h0300; mem_ack = 1'b0;
    #1;
    chk("mr_exec_we", reg_we, 32'd0);
    @(negedge clk);
    #1;
    chk("mr_mem_req", mem_req, 32'd1);
    #2;
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1;
    chk("mr_reg_we", reg_we, 32'd0);
    chk("mr_req", mem_req, 32'd0);
    chk("mr_pc", pc, 32'h10);
    chk("mr_pc_rel", pc_b, 32'h10);
    chk("mr_cnt", retire_cnt, 32'h0);
    chk("mr_inst", inst, 32'h0);
    @(negedge clk);
    #1;
    chk("mr_hold_we", reg_we, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ctrl_flags = 8'h00;
    pa = 15'h0010; pb = 15'h0010; cnt = 4'd0; inst_m = 16'h0000;
    #1;
    chk("mr_rel_req_low", mem_req, 32'd0);
    fetch(16'h0000, 0);
    chk("mr_restart_addr", mem_addr, 32'h0020);
    exec_alu(8'h00, 2'b00, 16'h2222, 16'h2222, pa, pb);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameters SHALL be: XLEN, default 16, datapath width; IMM_W, default 8, immediate field width (<= XLEN); RESET_PC, default 0, halfword PC after reset; REL_BRANCH, default 0, where 1 makes ipc targets PC-relative; CNT_W, default 16, retire counter width.
REQ-002 Ports SHALL be exactly as follows.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flags  in  2  ALU status: bit0 = zero, bit1 = carry.
- ctrl_flags  in  8  [7]cond [6]adi [5]ipc [4]wpc [3]spc [2]mem_we_op [1]mem_re_op [0]ldi.
- imm3  in  1  selects 3-bit zero-extended inst[2:0] as alu_b.
- reg_o0, reg_o2  in  XLEN  register file read data.
- alu_out  in  XLEN  ALU result.
- mem_rdata  in  XLEN  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completes the pending request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for mem_req.
- mem_half  out  1  1 = halfword access, 0 = byte access.
- mem_addr  out  XLEN  byte address.
- mem_wdata  out  XLEN  store data, equal to reg_o0.
- inst  out  XLEN  latched instruction.
- reg_in  out  XLEN  register write data.
- reg_we  out  1  register write strobe, one cycle.
- alu_b  out  XLEN  ALU operand B.
- pc  out  XLEN-1  halfword program counter.
- retire_cnt  out  CNT_W  retired-instruction count.

Function
REQ-003 The FSM SHALL have three states, FETCH, EXEC and MEM, with transitions only on a rising clk edge.
REQ-004 In FETCH the block SHALL drive mem_req=1, mem_we=0, mem_half=1 and mem_addr={pc,1'b0}, and SHALL hold these until mem_ack=1.
REQ-005 On FETCH with mem_ack=1 the block SHALL latch inst<=mem_rdata, set pc<=pc+1 (wrapping modulo 2^(XLEN-1)) and go to EXEC.
REQ-006 EXEC SHALL last exactly one cycle.
- mem_re_op or mem_we_op set: go to MEM, no register write, no branch.
- Otherwise: reg_we=1, go to FETCH, increment retire_cnt.
REQ-007 Branch rule for EXEC non-memory instructions: taken when cond=0 or the condition is true, where cond_sel=inst[11:10] gives 00 always, 01 flags[0], 10 flags[1], 11 (~flags[0] | ~flags[1]).
REQ-008 When a branch is taken:
- wpc=1 (priority over ipc): pc<=alu_out[XLEN-1:1].
- ipc=1, REL_BRANCH=0: pc<=zero-extended inst[IMM_W-1:1].
- ipc=1, REL_BRANCH=1: pc<=pc + sign-extended inst[IMM_W-1:1].
A branch update SHALL replace the increment done in the preceding FETCH.
REQ-009 In MEM the block SHALL drive mem_req=1, mem_addr=alu_out, mem_we=mem_we_op and mem_half=inst[3], held until mem_ack=1.
REQ-010 On MEM with mem_ack=1 the block SHALL go to FETCH, assert reg_we=1 only for loads (mem_we_op=0) and increment retire_cnt.
REQ-011 reg_in SHALL be selected in priority order:
- spc: {pc,1'b0}.
- ldi: IMM_W sign-extended inst[IMM_W-1:0].
- MEM state: mem_rdata.
- Otherwise: alu_out.
REQ-012 alu_b SHALL be selected in priority order:
- adi: sign-extended inst[3:0].
- imm3: zero-extended inst[2:0].
- Otherwise: reg_o2.
REQ-013 reg_we SHALL be 0 in FETCH and MEM except as given in REQ-010; mem_req SHALL be 0 in EXEC.
REQ-014 retire_cnt SHALL wrap from all-ones to 0.
REQ-015 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-016 While rst_n=0 the block SHALL hold state=FETCH, pc=RESET_PC, inst=0 and retire_cnt=0.
REQ-017 While rst_n=0, reg_we SHALL be 0.
REQ-018 A reset asserted mid-transaction SHALL abandon it, with no reg_we and no pc change.
REQ-019 mem_req SHALL first assert on the first clk edge after rst_n rises.

Verification
REQ-020 Reset with RESET_PC=0x10, then mem_ack=1 every cycle -> mem_addr=0x0020 in FETCH, pc=0x11 in EXEC.
REQ-021 mem_ack delayed 3 cycles in FETCH -> mem_req and mem_addr stable for 4 cycles, inst latched once.
REQ-022 Load with alu_out=0x0100 and mem_rdata=0xBEEF -> MEM mem_addr=0x0100, reg_we=1 with reg_in=0xBEEF, retire_cnt+1.
REQ-023 cond=1, cond_sel=01, ipc=1, inst[7:0]=0x40, flags=00 -> pc unchanged; repeat with flags=01 -> pc=0x20 (REL_BRANCH=0).
REQ-024 REL_BRANCH=1, pc=0x05, inst[7:0]=0xFC, ipc=1, cond=0 -> pc=0x03.
REQ-025 retire_cnt preloaded to all-ones by retiring 2^CNT_W-1 instructions (CNT_W=4), then one more retire -> retire_cnt=0.
